// File: rtl/ntru_sq_pkg.sv
// Shared definitions for the NTRU polynomial-multiply square controller:
// default sizing, the controller state encoding and a small counter helper.
package ntru_sq_pkg;

    // Default polynomial length, coefficient width (log2 q) and drain length
    localparam int N_DEFAULT     = 701;
    localparam int W_DEFAULT     = 13;
    localparam int DRAIN_DEFAULT = 2;

    // Width of the coefficient counter and of the coefficient address bus
    localparam int CNT_W = 10;

    // Controller states, all held in one state register
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_FIN
    } state_t;

    // Terminal count for a phase lasting `len` cycles; a zero-length phase
    // is never entered, so its limit value is irrelevant and pinned to 0.
    function automatic logic [CNT_W-1:0] term_count(input int len);
        logic [CNT_W-1:0] lim;
        lim = '0;
        if (len > 0) begin
            lim = CNT_W'(len - 1);
        end
        return lim;
    endfunction

endpackage

// File: rtl/poly_mul_sq_ctrl_coef_counter.sv
// Loadable up-counter with a terminal-count flag. The count stops at the
// limit instead of wrapping, so the address derived from it stays in range.
module coef_counter
    import ntru_sq_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          tc
);

    // Terminal count: the current value has reached the selected limit
    assign tc = (count == limit);

    // Count register: reset and load take priority, saturate at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && !tc) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/poly_mul_sq_ctrl.sv
// Sequencer for the schoolbook polynomial multiplier: clears the
// accumulator, streams N coefficients from memory into the datapath, lets
// the pipeline drain, then signals completion with a one-cycle done pulse.
module poly_mul_sq_ctrl
    import ntru_sq_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int W     = W_DEFAULT,
    parameter int DRAIN = DRAIN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             c_rd,
    output logic [CNT_W-1:0] c_addr,
    input  logic [W-1:0]     c_data,
    output logic             mul_en,
    output logic [W-1:0]     mul_c,
    output logic             mul_run
);

    localparam logic [CNT_W-1:0] FEED_LIM  = term_count(N);
    localparam logic [CNT_W-1:0] DRAIN_LIM = term_count(DRAIN);

    state_t           state;
    state_t           state_next;

    logic             cnt_load;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_limit;
    logic [CNT_W-1:0] count;
    logic             cnt_tc;

    // One counter serves both timed phases: FEED counts coefficients,
    // DRAIN counts idle cycles. It is reloaded to zero on every state change.
    coef_counter #(
        .CW(CNT_W)
    ) u_coef_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val ('0),
        .en       (cnt_en),
        .limit    (cnt_limit),
        .count    (count),
        .tc       (cnt_tc)
    );

    // State register; reset overrides start and abort
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort cancels any phase except the final FIN cycle
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_next = abort ? S_IDLE : S_FEED;
            end
            S_FEED: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt_tc) begin
                    state_next = (DRAIN > 0) ? S_DRAIN : S_FIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt_tc) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Counter control: restart from zero whenever the phase changes
    always_comb begin
        cnt_load  = (state_next != state) || (state == S_IDLE);
        cnt_en    = (state == S_FEED) || (state == S_DRAIN);
        cnt_limit = (state == S_DRAIN) ? DRAIN_LIM : FEED_LIM;
    end

    // Moore outputs; in FEED the read for coefficient k+1 overlaps the use
    // of coefficient k, and the final FEED cycle issues no read at all
    always_comb begin
        busy    = (state != S_IDLE);
        done    = 1'b0;
        c_rd    = 1'b0;
        c_addr  = '0;
        mul_en  = 1'b0;
        mul_c   = '0;
        mul_run = 1'b0;
        case (state)
            S_CLEAR: begin
                mul_en = 1'b1;
                c_rd   = 1'b1;
                c_addr = '0;
            end
            S_FEED: begin
                mul_run = 1'b1;
                mul_c   = c_data;
                if (!cnt_tc) begin
                    c_rd   = 1'b1;
                    c_addr = count + CNT_W'(1);
                end
            end
            S_FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
